// File: rtl/harmonic_mixer.sv
// harmonic_mixer: collects one sine sample per harmonic each sample tick, scales
// each by a geometrically decaying level, and emits one saturated mixed sample.
module harmonic_mixer #(
   parameter int NUM_HARMONICS = 64,
   parameter int ACC_WIDTH     = 32,
   parameter int OUT_SHIFT     = 8
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_sample_tick,
   input  logic [7:0]  i_harmonic_count,
   input  logic [2:0]  i_decay,
   input  logic        i_sample_ready,
   input  logic [15:0] i_sample_value,
   output logic [7:0]  o_harmonic,
   output logic        o_next_sample,
   output logic [15:0] o_mix_value,
   output logic        o_mix_valid,
   output logic        o_overrun
);
   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = 32767;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -32768;
   state_t state_q, state_d;
   logic [7:0] last_q, last_d, harm_q, harm_d, level_q, level_d;
   logic [2:0] decay_q, decay_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d, shifted;
   logic next_q, next_d, valid_q, valid_d, overrun_q, overrun_d;
   logic [15:0] mix_q, mix_d;
   logic signed [24:0] prod;
   logic [8:0] clamped;
   logic accept;
   assign clamped = (i_harmonic_count == 8'd0) ? 9'd1 :
                    ({1'b0, i_harmonic_count} > 9'(NUM_HARMONICS)) ? 9'(NUM_HARMONICS) :
                    {1'b0, i_harmonic_count};
   // ready seen while next_sample is high belongs to the sample just consumed
   assign accept  = (state_q == COLLECT) && i_sample_ready && !next_q;
   assign prod    = $signed(i_sample_value) * $signed({1'b0, level_q});
   assign shifted = acc_q >>> OUT_SHIFT;
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      decay_d   = decay_q;
      acc_d     = acc_q;
      level_d   = level_q;
      harm_d    = harm_q;
      mix_d     = mix_q;
      next_d    = 1'b0;
      valid_d   = 1'b0;
      overrun_d = i_sample_tick && (state_q != IDLE);
      unique case (state_q)
         IDLE: if (i_sample_tick) begin
            last_d  = 8'(clamped - 9'd1);
            decay_d = i_decay;
            acc_d   = '0;
            level_d = 8'd255;
            harm_d  = 8'd0;
            state_d = COLLECT;
         end
         COLLECT: if (accept) begin
            acc_d   = acc_q + ACC_WIDTH'(prod);
            next_d  = 1'b1;
            level_d = (decay_q == 3'd0) ? level_q : level_q - (level_q >> decay_q);
            harm_d  = (harm_q == last_q) ? 8'd0 : 8'(harm_q + 8'd1);
            state_d = (harm_q == last_q) ? DONE : COLLECT;
         end
         DONE: begin
            mix_d   = (shifted > SAT_MAX) ? 16'h7FFF : (shifted < SAT_MIN) ? 16'h8000 : shifted[15:0];
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= IDLE;
         last_q    <= '0;
         decay_q   <= '0;
         acc_q     <= '0;
         level_q   <= 8'd255;
         harm_q    <= '0;
         mix_q     <= '0;
         next_q    <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         decay_q   <= decay_d;
         acc_q     <= acc_d;
         level_q   <= level_d;
         harm_q    <= harm_d;
         mix_q     <= mix_d;
         next_q    <= next_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end
   assign o_harmonic    = harm_q;
   assign o_next_sample = next_q;
   assign o_mix_value   = mix_q;
   assign o_mix_valid   = valid_q;
   assign o_overrun     = overrun_q;
endmodule
